// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32I core.
// Holds fetch FSM states, default reset PC and instruction width.
package rv32i_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HALT  = 2'd2
    } ifbState_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: DEPTH-entry prefetch FIFO of {pc, instr} pairs.
// Supports flush, simultaneous push/pop and exposes occupancy.
module ifb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  pushData,
    input  logic          pop,
    output logic [W-1:0]  headData,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign doPop    = pop && !flush && (count != '0);
    assign doPush   = push && !flush && ((count != FULL) || doPop);
    assign headData = mem[rdPtr];

    // Storage, pointers and occupancy; flush empties without clearing data.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: RV32I fetch unit, one outstanding imem request,
// prefetch FIFO to decode, redirect flush. Option: IFB_MISALIGN_TRAP_EN.
module instr_fetch_buffer
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    input  logic               id_ready,
    output logic               misalign_trap
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifbState_t     state;
    ifbState_t     stateNext;
    logic          reqPending;
    logic          reqNext;
    logic [31:0]   reqAddr;
    logic [31:0]   reqAddrNext;
    logic [31:0]   fetchPc;
    logic [31:0]   fetchPcNext;
    logic          trap;
    logic          trapNext;
    logic          push;
    logic          flush;
    logic          pop;
    logic          ackNow;
    logic          redirBad;
    logic [31:0]   redirPc;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [63:0]   headData;

`ifdef IFB_MISALIGN_TRAP_EN
    assign redirPc  = redirect_pc;
    assign redirBad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redirPc  = wordAlign(redirect_pc);
    assign redirBad = 1'b0;
`endif

    assign ackNow        = reqPending && imem_ack;
    assign id_valid      = (count != '0);
    assign pop           = id_valid && id_ready && !redirect_valid;
    assign imem_req      = reqPending;
    assign imem_addr     = reqAddr;
    assign id_pc         = headData[63:32];
    assign id_instr      = headData[31:0];
    assign misalign_trap = trap;

    ifb_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) uFifo (
        .clk      (CLK),
        .rstN     (RESETn),
        .flush    (flush),
        .push     (push),
        .pushData ({fetchPc, imem_rdata}),
        .pop      (pop),
        .headData (headData),
        .count    (count)
    );

    // Fetch FSM: next state, request issue and fetch PC update.
    always_comb begin
        stateNext   = state;
        reqNext     = reqPending;
        reqAddrNext = reqAddr;
        fetchPcNext = fetchPc;
        trapNext    = trap | redirBad;
        push        = 1'b0;
        flush       = redirect_valid;
        countNext   = count;
        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    fetchPcNext = redirPc;
                    if (reqPending && !imem_ack) begin
                        stateNext = DROP;
                    end else if (redirBad) begin
                        stateNext = HALT;
                        reqNext   = 1'b0;
                    end else begin
                        reqNext     = 1'b1;
                        reqAddrNext = redirPc;
                    end
                end else begin
                    push = ackNow;
                    if (ackNow) begin
                        fetchPcNext = fetchPc + 32'd4;
                    end
                    countNext = count + CW'(push) - CW'(pop);
                    if (!reqPending || ackNow) begin
                        reqNext     = (countNext < DEPTH_C);
                        reqAddrNext = fetchPcNext;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    fetchPcNext = redirPc;
                end
                if (ackNow) begin
                    if (trapNext) begin
                        stateNext = HALT;
                        reqNext   = 1'b0;
                    end else begin
                        stateNext   = FETCH;
                        reqNext     = 1'b1;
                        reqAddrNext = fetchPcNext;
                    end
                end
            end
            HALT: begin
                reqNext = 1'b0;
            end
            default: begin
                stateNext = FETCH;
                reqNext   = 1'b0;
            end
        endcase
    end

    // State, request and PC registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= FETCH;
            reqPending <= 1'b0;
            reqAddr    <= RESET_PC;
            fetchPc    <= RESET_PC;
            trap       <= 1'b0;
        end else begin
            state      <= stateNext;
            reqPending <= reqNext;
            reqAddr    <= reqAddrNext;
            fetchPc    <= fetchPcNext;
            trap       <= trapNext;
        end
    end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction fetch unit for the RV32I core: issues word fetches to instruction memory over a req/ack handshake, holds returned words with their PC in a small prefetch FIFO, and presents them to the decode stage with a valid/ready handshake. It sits directly upstream of decode. Decode derives `ImmSrc` and the `InstrImm[31:7]` field from `id_instr` for immediate extension. A redirect from execute (branch/jump taken) flushes all buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: FIFO entries. Legal values are 2 or 4.

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RESETn`, input, 1: asynchronous, active-low reset.
- `redirect_valid`, input, 1: taken branch/jump from execute.
- `redirect_pc`, input, 32: new fetch target.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address. Word aligned.
- `imem_ack`, input, 1: response valid. `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: fetched word.
- `id_valid`, output, 1: FIFO head valid.
- `id_instr`, output, 32: head instruction.
- `id_pc`, output, 32: head PC.
- `id_ready`, input, 1: decode accepts the head.
- `misalign_trap`, output, 1: sticky misaligned-redirect flag. Tied 0 without the macro.

## Operation
- FSM states:
  - FETCH: normal operation.
  - DROP: discarding one stale in-flight response.
  - HALT: trap. Exists only with the macro.
- Exactly one request outstanding at a time.
  - `imem_req` rises only when `count + 0 < DEPTH`. An in-flight request reserves a slot.
  - `imem_req` and `imem_addr` are held stable until `imem_ack`.
- On `imem_ack` in FETCH: push {`fetch_pc`, `imem_rdata`}, then `fetch_pc <= fetch_pc + 4`. Wrap at 2^32 is modulo.
- Pop occurs when `id_valid && id_ready`. Push and pop may happen in the same cycle; count is then unchanged.
- `id_valid = (count != 0)`. `id_instr` and `id_pc` show the head entry and are don't-care when `id_valid` is 0.
- Redirect handling (it has priority over every other event in that cycle):
  - FIFO count goes to 0 and any same-cycle pop is ignored.
  - `fetch_pc <= redirect_pc`.
  - Request in flight and no ack this cycle: go to DROP and keep `imem_req`/`imem_addr` stable until the ack. That ack is discarded, then return to FETCH at the new PC.
  - Ack in the same cycle as the redirect: data discarded, stay in FETCH.
  - Redirect while in DROP: update `fetch_pc` and stay in DROP.
- Reset mid-transfer abandons the request. The memory side must tolerate a dropped request on reset.

## Timing
- During reset:
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `id_valid`=0, `id_instr`=0, `id_pc`=0
  - `misalign_trap`=0
  - count=0, state=FETCH
- `imem_req` asserts in the first clock edge cycle after `RESETn` deasserts.
- Ack in cycle N: `id_valid` is high in N+1. The next request may assert in N+1.
- Sustained throughput is 1 instruction per cycle when memory acks in 0 wait cycles and `id_ready` is held high.
- Redirect in cycle N: `id_valid`=0 in N+1. The new-PC request asserts in N+1 from FETCH, or in the cycle after the stale ack from DROP.
- FIFO full: `imem_req` stays low until a pop. The pop frees a slot and the request asserts in the next cycle.

## Configuration
- `IFB_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign_trap`, which stays set until reset.
  - The FIFO is flushed and the FSM enters HALT. It follows the DROP rule first if a request is in flight.
  - HALT issues no requests; `id_valid`=0 until reset.
- Undefined: `redirect_pc[1:0]` is forced to 2'b00 and `misalign_trap` is tied 0.

## Structure
- Shared package `rv32i_pkg` holds:
  - FSM state constants FETCH/DROP/HALT.
  - Default `RESET_PC`.
  - Instruction-width constant (32).
- Sub-module `ifb_fifo`: parameterised DEPTH×64-bit synchronous FIFO storing {pc, instr}. It has a flush input, simultaneous push/pop, and count output. The FSM and PC logic stay in the top module.

## Test plan
- Reset release, `RESET_PC`=0x100, 0-wait acks, `id_ready`=1: `id_pc` sequence is 0x100, 0x104, 0x108 on consecutive cycles.
- `id_ready`=0 with 0-wait acks: 2 entries accepted, `imem_req` low. Raise `id_ready` for one cycle: exactly one new request, and `id_pc`=0x104 follows 0x100.
- Redirect to 0x200 with a request outstanding and ack 3 cycles later: the ack data is not presented. The next request address is 0x200 and the first `id_pc` after the redirect is 0x200.
- Redirect to 0x40 in the same cycle as an ack and a pop: FIFO empty the next cycle, the acked word is dropped, and the next request is for 0x40.
- With the macro, redirect to 0x202: `misalign_trap`=1 and stays 1, no further `imem_req`, `id_valid`=0. Without the macro: fetch resumes at 0x200.
- `RESETn` asserted while `imem_req` is high and the FIFO is full: all outputs reach reset values asynchronously, and after release the first request is at `RESET_PC`.
